spiflash_read_arbiter: RTL

- Shares the single SPI flash between two read requesters.
- Port 0 is the ROM loader that copies the 48K ROM image into BRAM at boot. Port 1 is the tape/snapshot loader.
- Runs single-lane SPI mode 0 read transactions (0x03 READ, or 0x0B FAST READ when the optional feature is compiled in) and streams the returned bytes to the granted requester.
- Sits between the spectrum core's loaders and the flash_csn/flash_sck/flash_mosi/flash_miso pins, and is exercised in simulation against sim_spiflash.

---
 rtl/spiflash_read_arbiter_if.sv | 29 ++
 rtl/spiflash_read_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/spiflash_read_arbiter_if.sv
// Requester-side bus of spiflash_read_arbiter: two read ports plus the shared read-data byte.
interface spiflash_read_arbiter_if #(
    parameter int LEN_W = 16
);
    logic             req0;
    logic [23:0]      addr0;
    logic [LEN_W-1:0] len0;
    logic             gnt0;
    logic             valid0;
    logic             done0;
    logic             req1;
    logic [23:0]      addr1;
    logic [LEN_W-1:0] len1;
    logic             gnt1;
    logic             valid1;
    logic             done1;
    logic [7:0]       rdata;
    logic             busy;

    modport master (
        output req0, addr0, len0, req1, addr1, len1,
        input  gnt0, valid0, done0, gnt1, valid1, done1, rdata, busy
    );

    modport slave (
        input  req0, addr0, len0, req1, addr1, len1,
        output gnt0, valid0, done0, gnt1, valid1, done1, rdata, busy
    );
endinterface

// File: rtl/spiflash_read_arbiter.sv
// Two-port round-robin arbiter issuing SPI mode 0 flash reads (0x03).
// Define SPIFLASH_FAST_READ_EN for 0x0B FAST READ with 8 dummy clocks.
module spiflash_read_arbiter #(
    parameter int DESEL_CYCLES = 4,
    parameter int LEN_W        = 16
) (
    input  logic                   clock_12,
    input  logic                   reset,
    spiflash_read_arbiter_if.slave bus,
    output logic                   flash_csn,
    output logic                   flash_sck,
    output logic                   flash_mosi,
    input  logic                   flash_miso
);
`ifdef SPIFLASH_FAST_READ_EN
    localparam logic [7:0] CMD_BYTE = 8'h0B;
`else
    localparam logic [7:0] CMD_BYTE = 8'h03;
`endif

    typedef enum logic [2:0] {IDLE, SEL, CMD, ADDR, DUMMY, DATA, DESEL} state_t;

    state_t           state;
    logic             sel;        // port currently granted
    logic             last_port;  // port granted most recently
    logic [23:0]      addr_q;
    logic [LEN_W-1:0] len_q;
    logic [31:0]      out_sr;
    logic [6:0]       in_sr;
    logic [4:0]       bit_cnt;
    logic [3:0]       desel_cnt;
    logic             gnt0_q, gnt1_q, valid0_q, valid1_q, done0_q, done1_q;
    logic [7:0]       rdata_q;
    logic             busy_q;
    logic             grant0;

    assign grant0 = bus.req0 && (!bus.req1 || last_port);

    always_ff @(posedge clock_12) begin
        if (reset) begin
            state      <= IDLE;
            sel        <= 1'b0;
            last_port  <= 1'b1;
            addr_q     <= '0;
            len_q      <= '0;
            out_sr     <= '0;
            in_sr      <= '0;
            bit_cnt    <= '0;
            desel_cnt  <= '0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            valid0_q   <= 1'b0;
            valid1_q   <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
            flash_csn  <= 1'b1;
            flash_sck  <= 1'b0;
            flash_mosi <= 1'b0;
        end else begin
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            valid0_q <= 1'b0;
            valid1_q <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant0) begin
                        gnt0_q    <= 1'b1;
                        sel       <= 1'b0;
                        last_port <= 1'b0;
                        addr_q    <= bus.addr0;
                        len_q     <= bus.len0;
                        busy_q    <= 1'b1;
                        state     <= SEL;
                    end else if (bus.req1) begin
                        gnt1_q    <= 1'b1;
                        sel       <= 1'b1;
                        last_port <= 1'b1;
                        addr_q    <= bus.addr1;
                        len_q     <= bus.len1;
                        busy_q    <= 1'b1;
                        state     <= SEL;
                    end
                end
                SEL: begin
                    if (len_q == '0) begin
                        done0_q   <= !sel;
                        done1_q   <= sel;
                        desel_cnt <= '0;
                        state     <= DESEL;
                    end else begin
                        flash_csn  <= 1'b0;
                        flash_sck  <= 1'b0;
                        flash_mosi <= CMD_BYTE[7];
                        out_sr     <= {CMD_BYTE[6:0], addr_q, 1'b0};
                        bit_cnt    <= '0;
                        state      <= CMD;
                    end
                end
                CMD, ADDR, DUMMY: begin
                    // Header bits shift out of out_sr on the falling edge; it is zero-filled, so dummy bits are 0.
                    if (!flash_sck) begin
                        flash_sck <= 1'b1;
                    end else begin
                        flash_sck  <= 1'b0;
                        flash_mosi <= out_sr[31];
                        out_sr     <= {out_sr[30:0], 1'b0};
                        bit_cnt    <= bit_cnt + 5'd1;
                        if (state == CMD && bit_cnt == 5'd7) begin
                            state   <= ADDR;
                            bit_cnt <= '0;
                        end else if (state == ADDR && bit_cnt == 5'd23) begin
`ifdef SPIFLASH_FAST_READ_EN
                            state   <= DUMMY;
`else
                            state   <= DATA;
`endif
                            bit_cnt <= '0;
                        end else if (state == DUMMY && bit_cnt == 5'd7) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                end
                DATA: begin
                    if (!flash_sck) begin
                        flash_sck <= 1'b1;
                    end else begin
                        flash_sck <= 1'b0;
                        if (bit_cnt == 5'd7) begin
                            rdata_q  <= {in_sr, flash_miso};
                            valid0_q <= !sel;
                            valid1_q <= sel;
                            bit_cnt  <= '0;
                            len_q    <= len_q - LEN_W'(1);
                            if (len_q == LEN_W'(1)) begin
                                done0_q   <= !sel;
                                done1_q   <= sel;
                                flash_csn <= 1'b1;
                                desel_cnt <= '0;
                                state     <= DESEL;
                            end
                        end else begin
                            in_sr   <= {in_sr[5:0], flash_miso};
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                DESEL: begin
                    if (desel_cnt == 4'(DESEL_CYCLES - 1)) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        desel_cnt <= desel_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt0   = gnt0_q;
    assign bus.gnt1   = gnt1_q;
    assign bus.valid0 = valid0_q;
    assign bus.valid1 = valid1_q;
    assign bus.done0  = done0_q;
    assign bus.done1  = done1_q;
    assign bus.rdata  = rdata_q;
    assign bus.busy   = busy_q;
endmodule
